// File: rtl/nfifo_rr_reader.sv
// nfifo_rr_reader
// Round-robin reader for a multi-flow upstream buffer. Each cycle it picks a
// flow to read (staying on the current flow for up to BURST_LEN reads), issues
// reads only while there is guaranteed room downstream, tracks each read with
// a tag through the fixed upstream latency, and collects returned words into a
// small output FIFO that feeds a valid/ready (active-low) consumer.
//
// Ports
//   clk            clock
//   reset          asynchronous, active-high reset
//   empty          per-flow empty flags from upstream
//   data_in        read data from upstream, LATENCY cycles after read
//   data_vld_in    data_in valid
//   block_addr     flow selected for reading (driven every cycle)
//   read           read strobe for block_addr
//   pipe_en        upstream pipeline enable, tied high
//   dst_data       output word (FIFO head)
//   dst_flow       flow number of dst_data
//   dst_src_rdy_n  output word valid, active-low
//   dst_dst_rdy_n  consumer ready, active-low
//   err            sticky protocol error (data/tag disagreement)

module nfifo_rr_reader #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned FLOWS      = 4,
    parameter int unsigned OUTPUT_REG = 1,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned BUF_DEPTH  = 4,
    localparam int unsigned FW        = $clog2(FLOWS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FLOWS-1:0]      empty,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_vld_in,
    output logic [FW-1:0]         block_addr,
    output logic                  read,
    output logic                  pipe_en,
    output logic [DATA_WIDTH-1:0] dst_data,
    output logic [FW-1:0]         dst_flow,
    output logic                  dst_src_rdy_n,
    input  logic                  dst_dst_rdy_n,
    output logic                  err
);

    localparam int unsigned LATENCY = 1 + OUTPUT_REG;
    localparam int unsigned CNT_W   = $clog2(BURST_LEN + 1);
    localparam int unsigned OCC_W   = $clog2(BUF_DEPTH + 1);
    localparam int unsigned AW      = $clog2(BUF_DEPTH);

    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);
    localparam logic [OCC_W:0]   DEPTH_MAX = (OCC_W + 1)'(BUF_DEPTH);
    localparam logic [AW-1:0]    LAST_IDX  = AW'(BUF_DEPTH - 1);
    localparam logic [FW-1:0]    PTR_INIT  = FW'(FLOWS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [FW-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OCC_W-1:0] infl_q, infl_d;

    logic [LATENCY-1:0] tag_vld_q;
    logic [FW-1:0]      tag_flow_q [LATENCY];

    logic [DATA_WIDTH-1:0] mem_data [BUF_DEPTH];
    logic [FW-1:0]         mem_flow [BUF_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  err_q;

    // ------------------------------------------------------------------
    // Flow selection
    // ------------------------------------------------------------------
    logic [FW-1:0] sel;
    logic [FW-1:0] cand;
    logic          found;
    logic          stay;
    logic          any_ready;

    // Continue the current grant while its flow has data and burst budget.
    assign stay      = ~empty[ptr_q] & (cnt_q < BURST_MAX);
    assign any_ready = ~(&empty);

    // Otherwise scan ptr+1 .. ptr+FLOWS; the current flow comes up last, so a
    // lone busy flow can still be re-granted after its burst expires.
    always_comb begin
        sel   = ptr_q;
        cand  = '0;
        found = stay;
        for (int unsigned i = 1; i <= FLOWS; i++) begin
            cand = ptr_q + FW'(i);
            if (!found && !empty[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Credit and read strobe
    // ------------------------------------------------------------------
    logic [OCC_W:0] committed;
    logic           credit;

    // Every read in flight already owns a FIFO slot; a pop this cycle is not
    // counted, which keeps the credit path independent of the consumer.
    assign committed = {1'b0, infl_q} + {1'b0, occ_q};
    assign credit    = committed < DEPTH_MAX;
    assign read      = any_ready & credit & ~reset;

    assign block_addr = sel;
    assign pipe_en    = 1'b1;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (read) begin
            if (stay) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                ptr_d = sel;
                cnt_d = CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline and in-flight counter
    // ------------------------------------------------------------------
    logic          tag_exit;
    logic [FW-1:0] exit_flow;

    assign tag_exit  = tag_vld_q[LATENCY-1];
    assign exit_flow = tag_flow_q[LATENCY-1];

    always_comb begin
        infl_d = infl_q;
        unique case ({read, tag_exit})
            2'b10:   infl_d = infl_q + OCC_W'(1);
            2'b01:   infl_d = infl_q - OCC_W'(1);
            default: infl_d = infl_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic push, pop, proto_err;

    // Returned data must line up exactly with an exiting tag; either side
    // alone is a protocol violation and the word is dropped.
    assign push      = tag_exit & data_vld_in;
    assign proto_err = tag_exit ^ data_vld_in;
    assign pop       = (occ_q != '0) & ~dst_dst_rdy_n;

    always_comb begin
        occ_d = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + AW'(1);
    endfunction

    assign dst_data      = mem_data[rd_ptr_q];
    assign dst_flow      = mem_flow[rd_ptr_q];
    assign dst_src_rdy_n = (occ_q == '0);
    assign err           = err_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q    <= PTR_INIT;
            cnt_q    <= BURST_MAX;
            infl_q   <= '0;
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            infl_q <= infl_d;
            occ_q  <= occ_d;
            if (push) begin
                wr_ptr_q <= wrap_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= wrap_inc(rd_ptr_q);
            end
            if (proto_err) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld_q <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_flow_q[i] <= '0;
            end
        end else begin
            tag_vld_q[0]  <= read;
            tag_flow_q[0] <= sel;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_flow_q[i] <= tag_flow_q[i-1];
            end
        end
    end

    // Storage array needs no reset; occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= data_in;
            mem_flow[wr_ptr_q] <= exit_flow;
        end
    end

endmodule

// File: tb/tb_nfifo_rr_reader.sv
// Testbench for nfifo_rr_reader (default parameters). A queue-based model
// decides reads, plays the upstream (returning data LATENCY cycles later) and
// predicts every output; a small table checks first-grant selection after reset.

module tb_nfifo_rr_reader;

    localparam int FLOWS     = 4;
    localparam int BURST     = 8;
    localparam int BUF_DEPTH = 4;
    localparam int LATENCY   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  empty;
    logic [63:0] data_in;
    logic        data_vld_in;
    logic [1:0]  block_addr;
    logic        read;
    logic        pipe_en;
    logic [63:0] dst_data;
    logic [1:0]  dst_flow;
    logic        dst_src_rdy_n;
    logic        dst_dst_rdy_n;
    logic        err;

    always #5 clk = ~clk;

    nfifo_rr_reader dut (
        .clk           (clk),
        .reset         (reset),
        .empty         (empty),
        .data_in       (data_in),
        .data_vld_in   (data_vld_in),
        .block_addr    (block_addr),
        .read          (read),
        .pipe_en       (pipe_en),
        .dst_data      (dst_data),
        .dst_flow      (dst_flow),
        .dst_src_rdy_n (dst_src_rdy_n),
        .dst_dst_rdy_n (dst_dst_rdy_n),
        .err           (err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          flow;
        logic [63:0] data;
        int          due;
    } infl_t;
    typedef struct {
        int          flow;
        logic [63:0] data;
    } word_t;

    infl_t inflq[$];
    word_t fifoq[$];
    int    m_ptr, m_cnt;
    bit    m_err;
    int    cyc;
    int    f1_reads;
    int    step_idx;
    int    first_dst;
    int    rd_count;
    int    rd_log[$];
    int    dst_log[$];

    function automatic int model_sel(input logic [3:0] e);
        if (!e[m_ptr] && m_cnt < BURST) return m_ptr;
        for (int k = 1; k <= FLOWS; k++) begin
            int f;
            f = (m_ptr + k) % FLOWS;
            if (!e[f]) return f;
        end
        return m_ptr;
    endfunction

    function automatic void clear_stats();
        f1_reads  = 0;
        step_idx  = 0;
        first_dst = -1;
        rd_count  = 0;
        rd_log.delete();
        dst_log.delete();
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        data_vld_in = 1'b0;
        empty       = 4'hf;
        #1;
        chk("rst_read", 64'(read), 64'd0);
        chk("rst_src_rdy_n", 64'(dst_src_rdy_n), 64'd1);
        chk("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        m_ptr = FLOWS - 1;
        m_cnt = BURST;
        m_err = 1'b0;
        inflq.delete();
        fifoq.delete();
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance.
    task automatic step(input logic [3:0] e, input logic rn, input bit force_vld,
                        input bit drop_vld);
        bit          exit_now, vld, any, rd_exp, pop;
        int          sel;
        logic [63:0] nd;
        @(negedge clk);
        exit_now      = (inflq.size() > 0) && (inflq[0].due == cyc);
        vld           = (exit_now && !drop_vld) || force_vld;
        empty         = e;
        dst_dst_rdy_n = rn;
        data_vld_in   = vld;
        data_in       = exit_now ? inflq[0].data : {$urandom, $urandom};
        #1;
        any    = (e != 4'hf);
        sel    = model_sel(e);
        rd_exp = any && (inflq.size() + fifoq.size() < BUF_DEPTH);
        chk("read", 64'(read), 64'(rd_exp));
        if (any) chk("block_addr", 64'(block_addr), 64'(sel));
        chk("src_rdy_n", 64'(dst_src_rdy_n), 64'(fifoq.size() == 0));
        if (fifoq.size() > 0) begin
            chk("dst_data", dst_data, fifoq[0].data);
            chk("dst_flow", 64'(dst_flow), 64'(fifoq[0].flow));
        end
        chk("err", 64'(err), 64'(m_err));
        if (read === 1'b1) begin
            rd_count++;
            rd_log.push_back(int'(block_addr));
        end
        if (dst_src_rdy_n === 1'b0) begin
            if (first_dst < 0) first_dst = step_idx;
            if (!rn) dst_log.push_back(int'(dst_flow));
        end
        pop = (fifoq.size() > 0) && !rn;
        @(posedge clk);
        if (pop) void'(fifoq.pop_front());
        if (vld != exit_now) m_err = 1'b1;
        else if (exit_now) fifoq.push_back('{flow: inflq[0].flow, data: inflq[0].data});
        if (exit_now) void'(inflq.pop_front());
        if (rd_exp) begin
            nd = {$urandom, $urandom};
            inflq.push_back('{flow: sel, data: nd, due: cyc + LATENCY});
            if (sel == 1) f1_reads++;
            if (sel == m_ptr && m_cnt < BURST) begin
                m_cnt++;
            end else begin
                m_ptr = sel;
                m_cnt = 1;
            end
        end
        cyc++;
        step_idx++;
    endtask

    // ---------------- first-grant table ----------------
    typedef struct packed {
        logic [3:0] empty;
        logic       exp_read;
        logic       chk_addr;
        logic [1:0] exp_addr;
    } vec_t;
    vec_t vec[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        empty         = 4'hf;
        data_in       = '0;
        data_vld_in   = 1'b0;
        dst_dst_rdy_n = 1'b1;
        cyc           = 0;
        clear_stats();

        vec[0] = '{empty: 4'b1011, exp_read: 1'b1, chk_addr: 1'b1, exp_addr: 2'd2};
        vec[1] = '{empty: 4'b1101, exp_read: 1'b1, chk_addr: 1'b1, exp_addr: 2'd1};
        vec[2] = '{empty: 4'b0111, exp_read: 1'b1, chk_addr: 1'b1, exp_addr: 2'd3};
        vec[3] = '{empty: 4'b1110, exp_read: 1'b1, chk_addr: 1'b1, exp_addr: 2'd0};
        vec[4] = '{empty: 4'b0101, exp_read: 1'b1, chk_addr: 1'b1, exp_addr: 2'd1};
        vec[5] = '{empty: 4'b1111, exp_read: 1'b0, chk_addr: 1'b0, exp_addr: 2'd0};

        repeat (2) @(negedge clk);
        chk("pipe_en", 64'(pipe_en), 64'd1);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            @(negedge clk);
            empty         = vec[i].empty;
            dst_dst_rdy_n = 1'b0;
            #1;
            chk("tbl_read", 64'(read), 64'(vec[i].exp_read));
            if (vec[i].chk_addr) chk("tbl_addr", 64'(block_addr), 64'(vec[i].exp_addr));
            chk("tbl_src_rdy_n", 64'(dst_src_rdy_n), 64'd1);
        end

        // Only flow 2 busy, consumer ready: read every cycle, first word at +3.
        do_reset();
        clear_stats();
        for (int i = 0; i < 20; i++) step(4'b1011, 1'b0, 1'b0, 1'b0);
        chk("f2_reads", 64'(rd_count), 64'd20);
        chk("f2_first_dst", 64'(first_dst), 64'd3);
        chk("f2_words", 64'(dst_log.size()), 64'd17);

        // All flows busy: bursts of 8 in round-robin order, no gaps.
        do_reset();
        clear_stats();
        for (int i = 0; i < 72; i++) step(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("rr_reads", 64'(rd_count), 64'd72);
        begin
            int bad;
            bad = 0;
            foreach (rd_log[k]) if (rd_log[k] != (k / BURST) % FLOWS) bad++;
            chk("rr_order_errors", 64'(bad), 64'd0);
        end

        // Flows 1 and 2 busy, flow 1 drains after 3 reads.
        do_reset();
        clear_stats();
        for (int i = 0; i < 12; i++)
            step(4'b1001 | ((f1_reads >= 3) ? 4'b0010 : 4'b0000), 1'b0, 1'b0, 1'b0);
        begin
            int exp_seq[6] = '{1, 1, 1, 2, 2, 2};
            int bad;
            bad = 0;
            for (int k = 0; k < 6; k++) begin
                if (rd_log[k] != exp_seq[k]) bad++;
                if (dst_log[k] != exp_seq[k]) bad++;
            end
            chk("switch_seq_errors", 64'(bad), 64'd0);
            chk("switch_reads", 64'(rd_count), 64'd12);
        end

        // Consumer stalled from the start: exactly BUF_DEPTH reads, then drain.
        do_reset();
        clear_stats();
        for (int i = 0; i < 10; i++) step(4'b0000, 1'b1, 1'b0, 1'b0);
        chk("stall_reads", 64'(rd_count), 64'(BUF_DEPTH));
        chk("stall_src_rdy_n", 64'(dst_src_rdy_n), 64'd0);
        for (int i = 0; i < 10; i++) step(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("stall_drained", 64'(dst_log.size() >= 4), 64'd1);
        chk("stall_resumed", 64'(rd_count > BUF_DEPTH), 64'd1);

        // Spurious data valid with nothing outstanding: sticky error.
        do_reset();
        clear_stats();
        step(4'b1111, 1'b0, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(4'b1111, 1'b0, 1'b0, 1'b0);
        chk("spurious_err", 64'(err), 64'd1);
        chk("spurious_fifo", 64'(dst_src_rdy_n), 64'd1);

        // Missing data valid for an outstanding read: error, word dropped.
        do_reset();
        clear_stats();
        step(4'b1110, 1'b1, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b0, 1'b0);
        chk("drop_err", 64'(err), 64'd1);
        chk("drop_fifo_empty", 64'(dst_src_rdy_n), 64'd1);

        // Reset mid-operation with words in flight and buffered, error set.
        do_reset();
        clear_stats();
        step(4'b0000, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, 1'b0, 1'b0);
        do_reset();
        clear_stats();
        step(4'b1001, 1'b0, 1'b0, 1'b0);
        chk("post_rst_addr", 64'(rd_log.size() > 0 ? rd_log[0] : -1), 64'd1);

        // Randomized traffic.
        do_reset();
        clear_stats();
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] e;
            logic       rn;
            bit         fv;
            e  = 4'($urandom) | 4'($urandom);
            rn = ($urandom_range(0, 3) == 0);
            fv = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            step(e, rn, fv, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
